// File: rtl/vlg_gray_pkg.sv
// Shared Gray-code helpers for the counter and for any checker that needs
// to decode a Gray pointer. Functions operate on MAX_WIDTH-bit values;
// callers zero-extend narrower operands and truncate the result.
package vlg_gray_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned MAX_WIDTH = 32;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down recovers the binary value.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b = g;
    for (int unsigned i = 1; i < MAX_WIDTH; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/vlg_step_div.sv
// Prescaler producing a one-cycle step pulse every STEP_DIV clocks.
// With STEP_DIV = 1 the step output is tied high.
// Ports:
//   clk   - system clock, rising-edge active
//   rst_n - asynchronous active-low reset
//   step  - high for one clock when the divider reaches STEP_DIV-1
module vlg_step_div #(
  parameter int unsigned STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic step
);

  localparam int unsigned DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(STEP_DIV - 1);

  logic [DW-1:0] div_q;

  // For STEP_DIV = 1 div_q never leaves 0 and optimises away.
  assign step = (STEP_DIV == 1) ? 1'b1 : (div_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (step) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

endmodule

// File: rtl/vlg_design.sv
// Free-running Gray-code counter. o_gray is driven straight from a flop and
// changes by exactly one bit per step; one step every STEP_DIV clocks.
// Ports:
//   i_clk   - system clock, rising-edge active
//   i_rst_n - asynchronous active-low reset (clears count and output)
//   o_gray  - current Gray count, WIDTH bits, registered
module vlg_design
  import vlg_gray_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned STEP_DIV = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic [WIDTH-1:0] o_gray
);

  logic             step;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;

  vlg_step_div #(
    .STEP_DIV(STEP_DIV)
  ) u_step_div (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .step (step)
  );

  assign bin_nxt  = bin_q + WIDTH'(1);
  // Gray of the next count is registered alongside it, so o_gray is never
  // a combinational decode of bin_q.
  assign gray_nxt = WIDTH'(bin2gray(MAX_WIDTH'(bin_nxt)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bin_q  <= '0;
      o_gray <= '0;
    end else if (step) begin
      bin_q  <= bin_nxt;
      o_gray <= gray_nxt;
    end
  end

endmodule

// File: tb/tb_vlg_design.sv
// Bench for vlg_design: three instances (W4/div1, W4/div3, W5/div1) share
// clock and reset. Expected values come from the literal WIDTH=4 sequence
// and a reflected-Gray table built by mirroring.
module tb_vlg_design;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] g4;
  logic [3:0] g4d3;
  logic [4:0] g5;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] seq4 [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                            4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000};
  logic [4:0] seq5 [32];

  always #10 clk = ~clk;

  vlg_design #(.WIDTH(4), .STEP_DIV(1)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .o_gray(g4)
  );
  vlg_design #(.WIDTH(4), .STEP_DIV(3)) dut4d3 (
    .i_clk(clk), .i_rst_n(rst_n), .o_gray(g4d3)
  );
  vlg_design #(.WIDTH(5), .STEP_DIV(1)) dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .o_gray(g5)
  );

  // Reflected Gray construction: append the mirror image with a new top bit.
  task automatic build_seq5();
    int len;
    seq5[0] = 5'd0;
    seq5[1] = 5'd1;
    len = 2;
    for (int b = 1; b < 5; b++) begin
      for (int i = len - 1; i >= 0; i--) begin
        seq5[len + (len - 1 - i)] = seq5[i] | 5'(1 << b);
      end
      len = len * 2;
    end
  endtask

  function automatic int g2b4(input logic [3:0] g);
    logic [3:0] r;
    r[3] = g[3];
    for (int i = 2; i >= 0; i--) r[i] = r[i+1] ^ g[i];
    return int'(r);
  endfunction

  // Release lands on a falling edge; the next rising edge is edge 1.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (50) begin
      @(negedge clk);
      vectors++;
      if (g4 !== 4'b0000 || g4d3 !== 4'b0000 || g5 !== 5'b00000) begin
        miscompares++;
        $display("FAIL reset_hold: got %b/%b/%b want 0000/0000/00000", g4, g4d3, g5);
      end
    end
  endtask

  task automatic test_async_assert();
    int n;
    rst_n = 1'b1;
    n = $urandom_range(2, 10);
    repeat (n) @(posedge clk);
    #1;
    vectors++;
    if (g4 !== seq4[n % 16]) begin
      miscompares++;
      $display("FAIL pre_async: got %b want %b", g4, seq4[n % 16]);
    end
    #($urandom_range(1, 7));
    rst_n = 1'b0;
    #1;
    vectors++;
    if (g4 !== 4'b0000 || g5 !== 5'b00000) begin
      miscompares++;
      $display("FAIL async_assert: got %b/%b want 0000/00000", g4, g5);
    end
    @(negedge clk);
  endtask

  task automatic test_sequence();
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      vectors++;
      if (g4 !== seq4[k % 16]) begin
        miscompares++;
        $display("FAIL seq_edge%0d: got %b want %b", k, g4, seq4[k % 16]);
      end
    end
  endtask

  task automatic test_single_bit();
    logic [3:0] prev;
    prev = g4;
    repeat (1000) begin
      @(negedge clk);
      vectors++;
      if ($countones(g4 ^ prev) != 1) begin
        miscompares++;
        $display("FAIL single_bit: prev %b got %b", prev, g4);
      end
      vectors++;
      if (g2b4(g4) != (g2b4(prev) + 1) % 16) begin
        miscompares++;
        $display("FAIL bin_inc: prev %b got %b want bin %0d", prev, g4, (g2b4(prev) + 1) % 16);
      end
      prev = g4;
    end
  endtask

  task automatic test_mid_reset();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (g4 === 4'b1110) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL mid_reset_wait: got %b want 1110 within 40 cycles", g4);
    end
    #($urandom_range(1, 8));
    rst_n = 1'b0;
    #1;
    vectors++;
    if (g4 !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_reset_async: got %b want 0000", g4);
    end
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      vectors++;
      if (g4 !== 4'b0000) begin
        miscompares++;
        $display("FAIL mid_reset_hold: got %b want 0000", g4);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      vectors++;
      if (g4 !== seq4[k]) begin
        miscompares++;
        $display("FAIL mid_reset_resume%0d: got %b want %b", k, g4, seq4[k]);
      end
    end
  endtask

  task automatic test_step_div3();
    do_reset();
    for (int e = 1; e <= 54; e++) begin
      @(negedge clk);
      vectors++;
      if (g4d3 !== seq4[(e / 3) % 16]) begin
        miscompares++;
        $display("FAIL div3_edge%0d: got %b want %b", e, g4d3, seq4[(e / 3) % 16]);
      end
    end
  endtask

  task automatic test_width5();
    do_reset();
    for (int e = 1; e <= 34; e++) begin
      @(negedge clk);
      vectors++;
      if (g5 !== seq5[e % 32]) begin
        miscompares++;
        $display("FAIL w5_edge%0d: got %b want %b", e, g5, seq5[e % 32]);
      end
    end
  endtask

  initial begin
    build_seq5();
    test_reset();
    test_async_assert();
    test_sequence();
    test_single_bit();
    test_mid_reset();
    test_step_div3();
    test_width5();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
